fp_mul_seq: RTL
===============

FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 Parameter EXP_W, default 5, exponent field width.
REQ-002 Parameter MAN_W, default 10, stored mantissa (fraction) width; operand width W = 1+EXP_W+MAN_W (16 at defaults).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand pair a/b present.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 a, b  input  W each  IEEE-754-style operands {sign, exp, frac}.
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 result  output  W  product.
REQ-011 flags  output  4  {invalid, overflow, underflow, inexact}, bit 3 down to bit 0, valid with result.

Function
REQ-012 The block SHALL hold one operation at a time through states IDLE -> MUL -> NORM -> DONE -> IDLE.
REQ-013 in_ready SHALL be 1 only in IDLE; the transfer occurs on an edge where in_valid && in_ready, capturing a and b.
REQ-014 MUL SHALL compute the (MAN_W+1)x(MAN_W+1) significand product by radix-2 shift-add over exactly MAN_W+1 cycles into a 2*(MAN_W+1)-bit accumulator.
REQ-015 NORM SHALL take 1 cycle: normalise (at most one right shift, exponent +1), round to nearest-even using guard and sticky bits, and renormalise if rounding carries out.
REQ-016 out_valid SHALL rise exactly MAN_W+3 edges after the accepting edge (13 at defaults) and hold with result/flags stable until an edge with out_ready=1, then return to IDLE.
REQ-017 Back-to-back: in_ready SHALL be 1 in the cycle after the result handshake (no same-cycle accept while in DONE).
REQ-018 Exponent arithmetic SHALL use signed EXP_W+2 bits: e = ea + eb - BIAS (+ normalisation/round carry), BIAS = 2^(EXP_W-1)-1.
REQ-019 Sign SHALL be sign_a XOR sign_b for all results, including zero and infinity; NaN results use sign 0.
REQ-020 Subnormal inputs (exp=0, frac!=0) SHALL be treated as signed zero (flush-to-zero); no subnormal outputs are produced.
REQ-021 e >= 2^EXP_W-1 SHALL return signed infinity with overflow=1 and inexact=1.
REQ-022 e <= 0 after rounding SHALL return signed zero with underflow=1 and inexact=1.
REQ-023 NaN input, or infinity x zero, SHALL return canonical NaN (exp all-ones, frac MSB 1, rest 0) with invalid=1 only for inf x zero or a signalling NaN (frac MSB 0).
REQ-024 Infinity x finite non-zero SHALL return signed infinity, flags 0; zero x finite SHALL return signed zero, flags 0.
REQ-025 Special cases SHALL use the same fixed latency as normal operands.
REQ-026 inexact SHALL be 1 whenever guard or sticky is non-zero before rounding.

Reset
REQ-027 On rst=1 at an edge: state=IDLE, in_ready=1, out_valid=0, result=0, flags=0, accumulator and counters cleared.
REQ-028 rst SHALL override any operation in MUL, NORM or DONE; the in-flight operation is discarded with no output produced.
REQ-029 rst asserted in the same cycle as in_valid SHALL prevent capture.

Structure
REQ-030 Package fp_mul_pkg SHALL hold default EXP_W/MAN_W, the state enumeration, flag bit indices and the canonical-NaN/infinity field constants.
REQ-031 The shift-add significand multiplier SHALL be a sub-module fp_mant_mul_seq (start/done, parametrised on MAN_W+1); classification, normalisation and rounding stay in fp_mul_seq.

Verification
REQ-032 a=0x3C00 (1.0), b=0x3C00 -> result 0x3C00, flags 0000, out_valid 13 edges after accept.
REQ-033 a=0x3E00 (1.5), b=0x4000 (2.0) -> 0x4200; a=0xC000 (-2.0), b=0x3800 (0.5) -> 0xBC00; flags 0000.
REQ-034 a=0x7BFF (65504), b=0x4000 -> 0x7C00, flags 0101; a=0x0400, b=0x0400 -> 0x0000, flags 0011.
REQ-035 a=0x7C00 (inf), b=0x0000 -> 0x7E00, flags 1000; a=0x7C00, b=0xC000 -> 0xFC00, flags 0000.
REQ-036 out_ready held 0 for 5 cycles -> result and out_valid stable, in_ready=0 throughout; accept next pair on cycle after handshake.
REQ-037 rst pulsed during MUL -> out_valid stays 0, in_ready=1 next cycle, following operation 0x3C00 x 0x4000 returns 0x4000.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared constants and types for the sequential floating-point multiplier.
package fp_mul_pkg;

  localparam int DEF_EXP_W = 5;
  localparam int DEF_MAN_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  // Special values: exponent field filled with ones; NaN is {0, ones, 1, zeros}.
  localparam logic SPECIAL_EXP_BIT = 1'b1;
  localparam logic INF_FRAC_BIT    = 1'b0;
  localparam logic NAN_SIGN        = 1'b0;
  localparam logic NAN_FRAC_MSB    = 1'b1;

endpackage

// File: rtl/fp_mant_mul_seq.sv
// Radix-2 shift-add unsigned multiplier: loads on start, then one partial
// product per cycle for N cycles; done pulses once the product is complete.
module fp_mant_mul_seq #(
  parameter int N = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [N-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{N{1'b0}}, a};
      mplier <= b;
      cnt    <= CW'(N);
      busy   <= 1'b1;
    end else if (busy) begin
      if (cnt != '0) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
      end else begin
        busy <= 1'b0;
      end
    end
  end

  assign done    = busy && (cnt == '0);
  assign product = acc;

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754-style multiplier with flush-to-zero, RNE rounding and
// a fixed latency for all operand classes.
//
// state | meaning
// IDLE  | ready for an operand pair
// MUL   | significand shift-add in progress
// NORM  | normalise, round, classify; register result and flags
// DONE  | result held until out_ready
module fp_mul_seq
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int N    = MAN_W + 1;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic signed [EW-1:0] E_MAX  = EW'(EMAX);
  localparam logic signed [EW-1:0] E_ZERO = '0;

  state_t state, state_nxt;
  logic [W-1:0]   a_q, b_q;
  logic           mul_start, mul_done;
  logic [2*N-1:0] prod;
  logic [W-1:0]   res_nxt;
  logic [3:0]     flg_nxt;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign mul_start = in_valid && in_ready;

  fp_mant_mul_seq #(.N(N)) u_mant_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       ({|a[W-2:MAN_W], a[MAN_W-1:0]}),
    .b       ({|b[W-2:MAN_W], b[MAN_W-1:0]}),
    .done    (mul_done),
    .product (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      flags  <= '0;
    end else begin
      state <= state_nxt;
      if (mul_start) begin
        a_q <= a;
        b_q <= b;
      end
      if (state == ST_NORM) begin
        result <= res_nxt;
        flags  <= flg_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nxt = ST_MUL;
      ST_MUL:  if (mul_done)  state_nxt = ST_NORM;
      ST_NORM:                state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default:                state_nxt = ST_IDLE;
    endcase
  end

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, sign;
  logic             hi, guard, sticky, round_up, carry;
  logic [2*N-2:0]   norm;
  logic [MAN_W+1:0] sig_r;
  logic [MAN_W-1:0] frac_r;
  logic [EW-1:0]    e_u;
  logic signed [EW-1:0] e;

  always_comb begin
    ea     = a_q[W-2:MAN_W];
    eb     = b_q[W-2:MAN_W];
    fa     = a_q[MAN_W-1:0];
    fb     = b_q[MAN_W-1:0];
    sign   = a_q[W-1] ^ b_q[W-1];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (&ea) && (fa == '0);
    b_inf  = (&eb) && (fb == '0);
    a_nan  = (&ea) && (fa != '0);
    b_nan  = (&eb) && (fb != '0);
    a_snan = a_nan && !fa[MAN_W-1];
    b_snan = b_nan && !fb[MAN_W-1];

    // Leading one sits at bit 2N-1 or 2N-2; align it to bit 2N-2 and drop it.
    hi       = prod[2*N-1];
    norm     = hi ? prod[2*N-2:0] : {prod[2*N-3:0], 1'b0};
    guard    = norm[MAN_W];
    sticky   = |norm[MAN_W-1:0];
    round_up = guard && (sticky || norm[MAN_W+1]);
    sig_r    = {1'b0, 1'b1, norm[2*MAN_W:MAN_W+1]} + (MAN_W+2)'(round_up);
    carry    = sig_r[MAN_W+1];
    frac_r   = carry ? sig_r[MAN_W:1] : sig_r[MAN_W-1:0];
    e_u      = EW'(ea) + EW'(eb) - EW'(BIAS) + EW'(hi) + EW'(carry);
    e        = signed'(e_u);

    res_nxt = '0;
    flg_nxt = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      res_nxt = {NAN_SIGN, {EXP_W{SPECIAL_EXP_BIT}}, NAN_FRAC_MSB, {(MAN_W-1){1'b0}}};
      flg_nxt[FLAG_INVALID] = (a_inf && b_zero) || (b_inf && a_zero) || a_snan || b_snan;
    end else if (a_inf || b_inf) begin
      res_nxt = {sign, {EXP_W{SPECIAL_EXP_BIT}}, {MAN_W{INF_FRAC_BIT}}};
    end else if (a_zero || b_zero) begin
      res_nxt = {sign, {(W-1){1'b0}}};
    end else if (e >= E_MAX) begin
      res_nxt = {sign, {EXP_W{SPECIAL_EXP_BIT}}, {MAN_W{INF_FRAC_BIT}}};
      flg_nxt[FLAG_OVERFLOW] = 1'b1;
      flg_nxt[FLAG_INEXACT]  = 1'b1;
    end else if (e <= E_ZERO) begin
      res_nxt = {sign, {(W-1){1'b0}}};
      flg_nxt[FLAG_UNDERFLOW] = 1'b1;
      flg_nxt[FLAG_INEXACT]   = 1'b1;
    end else begin
      res_nxt = {sign, e_u[EXP_W-1:0], frac_r};
      flg_nxt[FLAG_INEXACT] = guard || sticky;
    end
  end

endmodule
